alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Sequencer for the ALU datapath (ALU, shifter, HI/LO divider, output mux).
//  - Accepts one decoded funct per start pulse.
//  - Drives the per-unit control signals and the output-mux select.
//  - Times the multi-cycle DIVU and reports ready/done/err to the top-level.
// PARAMETERS
//  DIV_CYCLES  32  cycles DIVU occupies the divider (>=2)
//  CNT_W       6   divide-counter width, must hold DIV_CYCLES-1
// PORTS
//  clk          in   1  rising-edge clock, single clock domain
//  reset        in   1  asynchronous, active-low reset
//  start        in   1  request valid; sampled only while ready=1
//  funct        in   6  AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, DIVU 011011, MFHI 010000, MFLO 010010
//  ready        out  1  combinational: a start this cycle is accepted
//  SignaltoALU  out  6  funct to ALU; 0 when unused
//  SignaltoSHT  out  6  funct to shifter; 0 when unused
//  SignaltoDIV  out  6  DIVU while dividing, else 0
//  div_load     out  1  one-cycle operand-load pulse to divider
//  SignaltoMUX  out  6  output-mux select; 0 (mux outputs 0) when idle
//  busy         out  1  DIVU in progress
//  done         out  1  one-cycle pulse: result valid on mux output
//  err          out  1  one-cycle pulse: illegal funct or rejected start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cnt=0, all outputs 0, pending cleared.
//  States: IDLE, EXEC, DIV.
//  - IDLE/EXEC + accepted legal non-DIVU start -> EXEC next cycle.
//    In EXEC, unit signal and SignaltoMUX = funct, done=1, for exactly 1 cycle.
//    - AND/OR/ADD/SUB/SLT drive SignaltoALU; SRL drives SignaltoSHT.
//    - MFHI/MFLO drive only SignaltoMUX.
//  - EXEC without a new start -> IDLE; all outputs return to 0.
//  - Accepted DIVU at cycle t -> DIV for cycles t+1..t+DIV_CYCLES.
//    - div_load=1 at t+1 only.
//    - SignaltoDIV = SignaltoMUX = DIVU and busy=1 throughout; cnt counts 0..DIV_CYCLES-1.
//    - done=1 at the cycle where cnt=DIV_CYCLES-1, then IDLE unless a start is accepted.
//  - ready = (state!=DIV) | (cnt==DIV_CYCLES-1), so back-to-back issue has zero bubbles.
//  - Illegal funct with start & ready: err=1 next cycle, no unit driven, no done, state->IDLE.
//  - start while ready=0: ignored, err=1 next cycle, divide continues undisturbed.
//  - Reset asserted mid-DIV: divide aborted immediately, no done.
// CONFIGURATION
//  HILO_INTERLOCK_EN defined:
//  - MFHI/MFLO arriving while busy is captured into a 1-entry pending slot.
//    No err. ready stays 1 for MFHI/MFLO only.
//  - The captured op executes as EXEC in the cycle after the DIVU done.
//  - A second request while the slot is full is rejected with err.
//  - Any non-MFHI/MFLO start during busy behaves as in the undefined case.
//  HILO_INTERLOCK_EN undefined: no pending slot; all starts during busy rejected as above.
// STRUCTURE
//  alu_ctrl_pkg: funct constants, state encoding, DIV_CYCLES default.
//  Sub-module div_cycle_counter: load/enable/terminal-count for DIV timing.
//  FSM, decode and output registers stay in alu_ctrl_seq; all outputs except ready are registered.
// TESTING
//  1 ADD start at t -> SignaltoALU=SignaltoMUX=100000, done=1 at t+1; all 0 at t+2.
//  2 SRL then AND on consecutive cycles:
//    - SignaltoSHT=000010 at t+1.
//    - SignaltoALU=100100 at t+2.
//    - done high both cycles.
//  3 DIVU at t:
//    - div_load only at t+1.
//    - busy t+1..t+32; done at t+32.
//    - ADD issued at t+32 -> executes at t+33.
//  4 ADD during DIVU busy -> err=1 next cycle, no SignaltoALU; DIVU done still at t+32.
//  5 Illegal funct 111111 -> err pulse, done=0, all signals 0.
//  6 reset low at DIVU t+10 -> outputs 0 at once; no done; fresh DIVU done after 32 cycles.
//  7 HILO_INTERLOCK_EN, MFHI during DIVU -> no err; SignaltoMUX=010000, done at t+33.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared funct encodings, FSM state type and op classification for the ALU sequencer.
package alu_ctrl_pkg;

  localparam int FUNCT_W        = 6;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int CNT_W_DEF      = 6;

  typedef logic [FUNCT_W-1:0] funct_t;

  localparam funct_t F_AND  = 6'b100100;
  localparam funct_t F_OR   = 6'b100101;
  localparam funct_t F_ADD  = 6'b100000;
  localparam funct_t F_SUB  = 6'b100010;
  localparam funct_t F_SLT  = 6'b101010;
  localparam funct_t F_SRL  = 6'b000010;
  localparam funct_t F_DIVU = 6'b011011;
  localparam funct_t F_MFHI = 6'b010000;
  localparam funct_t F_MFLO = 6'b010010;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DIV} state_t;

  typedef enum logic [2:0] {OC_ILL, OC_ALU, OC_SHT, OC_DIV, OC_MF} op_class_t;

  function automatic op_class_t classify(funct_t f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: classify = OC_ALU;
      F_SRL:                            classify = OC_SHT;
      F_DIVU:                           classify = OC_DIV;
      F_MFHI, F_MFLO:                   classify = OC_MF;
      default:                          classify = OC_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_div_cycle_counter.sv
// Divide-cycle counter: restarts at 0 on load, advances while enabled, flags the last
// cycle (tc) and the cycle before it (pre_tc) so the parent can register done.
module div_cycle_counter
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc,
  output logic o_pre_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + 1'b1;
    else             r_cnt <= '0;
  end

  assign o_tc     = (r_cnt == CNT_W'(DIV_CYCLES - 1));
  assign o_pre_tc = (r_cnt == CNT_W'(DIV_CYCLES - 2));

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU datapath sequencer: single-cycle ops, multi-cycle DIVU timing, ready/done/err.
// Optional HILO_INTERLOCK_EN: one-entry slot holding an MFHI/MFLO issued during a divide.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  output logic               ready,
  output logic [FUNCT_W-1:0] SignaltoALU,
  output logic [FUNCT_W-1:0] SignaltoSHT,
  output logic [FUNCT_W-1:0] SignaltoDIV,
  output logic               div_load,
  output logic [FUNCT_W-1:0] SignaltoMUX,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t    r_state;
  funct_t    r_alu, r_sht, r_div, r_mux;
  logic      r_div_load, r_busy, r_done, r_err;

  op_class_t w_class;
  logic      w_in_div, w_tc, w_pre_tc;
  logic      w_slot_free, w_accept, w_capture, w_pend_vld;
  funct_t    w_pend_funct;

  assign w_class     = classify(funct);
  assign w_in_div    = (r_state == ST_DIV);
  // On the last divide cycle a queued MFHI/MFLO owns the next cycle, so new issue waits.
  assign w_slot_free = !w_in_div || (w_tc && !w_pend_vld);
  assign w_accept    = start && w_slot_free;

  div_cycle_counter #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_div_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_accept && (w_class == OC_DIV)),
    .i_en    (w_in_div && !w_tc),
    .o_tc    (w_tc),
    .o_pre_tc(w_pre_tc)
  );

`ifdef HILO_INTERLOCK_EN
  logic   r_pend_vld;
  funct_t r_pend_funct;
  logic   w_can_capture;

  assign w_can_capture = w_in_div && !w_tc && (w_class == OC_MF) && !r_pend_vld;
  assign w_capture     = start && w_can_capture;
  assign ready         = w_slot_free || w_can_capture;
  assign w_pend_vld    = r_pend_vld;
  assign w_pend_funct  = r_pend_funct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld   <= 1'b0;
      r_pend_funct <= '0;
    end else if (w_capture) begin
      r_pend_vld   <= 1'b1;
      r_pend_funct <= funct;
    end else if (w_in_div && w_tc) begin
      r_pend_vld   <= 1'b0;
    end
  end
`else
  assign w_capture    = 1'b0;
  assign ready        = w_slot_free;
  assign w_pend_vld   = 1'b0;
  assign w_pend_funct = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_alu      <= '0;
      r_sht      <= '0;
      r_div      <= '0;
      r_mux      <= '0;
      r_div_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: defaults first, then overrides; the last non-blocking assignment wins,
      // so every output falls back to 0 unless this cycle's branch drives it.
      r_state    <= ST_IDLE;
      r_alu      <= '0;
      r_sht      <= '0;
      r_div      <= '0;
      r_mux      <= '0;
      r_div_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_accept) begin
        case (w_class)
          OC_ALU: begin
            r_state <= ST_EXEC;
            r_alu   <= funct;
            r_mux   <= funct;
            r_done  <= 1'b1;
          end
          OC_SHT: begin
            r_state <= ST_EXEC;
            r_sht   <= funct;
            r_mux   <= funct;
            r_done  <= 1'b1;
          end
          OC_MF: begin
            r_state <= ST_EXEC;
            r_mux   <= funct;
            r_done  <= 1'b1;
          end
          OC_DIV: begin
            r_state    <= ST_DIV;
            r_div      <= F_DIVU;
            r_mux      <= F_DIVU;
            r_div_load <= 1'b1;
            r_busy     <= 1'b1;
          end
          default: r_err <= 1'b1;
        endcase
      end else begin
        r_err <= start && !w_capture;
        if (w_in_div && !w_tc) begin
          r_state <= ST_DIV;
          r_div   <= F_DIVU;
          r_mux   <= F_DIVU;
          r_busy  <= 1'b1;
          r_done  <= w_pre_tc;
        end else if (w_in_div && w_pend_vld) begin
          r_state <= ST_EXEC;
          r_mux   <= w_pend_funct;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign SignaltoALU = r_alu;
  assign SignaltoSHT = r_sht;
  assign SignaltoDIV = r_div;
  assign SignaltoMUX = r_mux;
  assign div_load    = r_div_load;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus random traffic against a
// cycle-position reference model. Define HILO_INTERLOCK_EN to also cover the pending slot.
module tb_alu_ctrl_seq;

  localparam int N = 32;
  localparam logic [5:0] AND_F = 6'b100100, OR_F = 6'b100101, ADD_F = 6'b100000,
                         SUB_F = 6'b100010, SLT_F = 6'b101010, SRL_F = 6'b000010,
                         DIVU_F = 6'b011011, MFHI_F = 6'b010000, MFLO_F = 6'b010010;
`ifdef HILO_INTERLOCK_EN
  localparam bit ILK = 1'b1;
`else
  localparam bit ILK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] funct = '0;
  logic       ready, div_load, busy, done, err;
  logic [5:0] SignaltoALU, SignaltoSHT, SignaltoDIV, SignaltoMUX;

  alu_ctrl_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .ready      (ready),
    .SignaltoALU(SignaltoALU),
    .SignaltoSHT(SignaltoSHT),
    .SignaltoDIV(SignaltoDIV),
    .div_load   (div_load),
    .SignaltoMUX(SignaltoMUX),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  wire [27:0] obs_vec = {SignaltoALU, SignaltoSHT, SignaltoDIV, div_load,
                         SignaltoMUX, busy, done, err};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position inside the current divide (1..N, 0 = not dividing).
  int         div_pos;
  bit         pend;
  logic [5:0] pend_f;
  logic [27:0] exp_vec;
  bit         exp_ready, obs_ready;

  function automatic int fclass(logic [5:0] f);
    case (f)
      AND_F, OR_F, ADD_F, SUB_F, SLT_F: return 1;
      SRL_F:                            return 2;
      DIVU_F:                           return 3;
      MFHI_F, MFLO_F:                   return 4;
      default:                          return 0;
    endcase
  endfunction

  task automatic model_reset();
    div_pos = 0;
    pend    = 1'b0;
    pend_f  = '0;
    exp_vec = '0;
  endtask

  // Drive one cycle of input just after a falling edge, predict, advance to next falling edge.
  task automatic step(input bit s, input logic [5:0] f);
    bit acc, cap, ld, bz, dn, er;
    logic [5:0] alu, sht, dv, mux;
    int np;
    start = s;
    funct = f;
    #1;
    acc = (div_pos == 0) || (div_pos == N && !pend);
    cap = ILK && div_pos > 0 && div_pos < N && fclass(f) == 4 && !pend;
    exp_ready = acc || cap;
    obs_ready = ready;
    alu = '0; sht = '0; dv = '0; mux = '0; ld = 0; bz = 0; dn = 0; er = 0; np = 0;
    if (s && acc) begin
      case (fclass(f))
        1: begin alu = f; mux = f; dn = 1; end
        2: begin sht = f; mux = f; dn = 1; end
        3: begin np = 1; ld = 1; dv = DIVU_F; mux = DIVU_F; bz = 1; end
        4: begin mux = f; dn = 1; end
        default: er = 1;
      endcase
    end else begin
      if (s) begin
        if (cap) begin pend = 1'b1; pend_f = f; end
        else er = 1;
      end
      if (div_pos > 0 && div_pos < N) begin
        np = div_pos + 1; dv = DIVU_F; mux = DIVU_F; bz = 1; dn = (np == N);
      end else if (div_pos == N && pend) begin
        mux = pend_f; dn = 1; pend = 1'b0;
      end
    end
    div_pos = np;
    exp_vec = {alu, sht, dv, ld, mux, bz, dn, er};
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (obs_vec !== 28'h0) begin
      n_err++; $display("FAIL reset_outputs obs=%h exp=%h", obs_vec, 28'h0);
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready obs=%b exp=1", ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_add();
    step(1, ADD_F);
    n_vec++;
    if (obs_ready !== exp_ready || obs_vec !== exp_vec || SignaltoALU !== ADD_F || done !== 1'b1) begin
      n_err++; $display("FAIL add_exec obs=%h/%b exp=%h/%b", obs_vec, obs_ready, exp_vec, exp_ready);
    end
    step(0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec !== 28'h0) begin
      n_err++; $display("FAIL add_idle obs=%h exp=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    step(1, SRL_F);
    n_vec++;
    if (obs_vec !== exp_vec || SignaltoSHT !== SRL_F || done !== 1'b1) begin
      n_err++; $display("FAIL b2b_srl obs=%h exp=%h", obs_vec, exp_vec);
    end
    step(1, AND_F);
    n_vec++;
    if (obs_ready !== exp_ready || obs_vec !== exp_vec || SignaltoALU !== AND_F || done !== 1'b1) begin
      n_err++; $display("FAIL b2b_and obs=%h/%b exp=%h/%b", obs_vec, obs_ready, exp_vec, exp_ready);
    end
    step(0, '0);
  endtask

  // DIVU issued, optionally with a foreign start at cycle t+rej_at, then ADD at t+N.
  task automatic test_divu(input string tag, input int rej_at, input logic [5:0] rej_f);
    step(1, DIVU_F);
    n_vec++;
    if (obs_vec !== exp_vec || div_load !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL %s_load obs=%h exp=%h", tag, obs_vec, exp_vec);
    end
    for (int j = 1; j < N; j++) begin
      step(j == rej_at, (j == rej_at) ? rej_f : 6'h0);
      n_vec++;
      if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL %s_cyc%0d obs=%h/%b exp=%h/%b", tag, j + 1, obs_vec, obs_ready,
                          exp_vec, exp_ready);
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || div_load !== 1'b0) begin
      n_err++; $display("FAIL %s_done_at_N obs done=%b busy=%b exp done=1 busy=1", tag, done, busy);
    end
    step(1, ADD_F);
    n_vec++;
    if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL %s_add_after obs=%h/%b exp=%h/%b", tag, obs_vec, obs_ready,
                        exp_vec, exp_ready);
    end
    step(0, '0);
  endtask

  task automatic test_illegal();
    step(1, 6'b111111);
    n_vec++;
    if (obs_vec !== exp_vec || err !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL illegal obs=%h exp=%h", obs_vec, exp_vec);
    end
    step(0, '0);
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++; $display("FAIL illegal_after obs=%h exp=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_reset_mid_div();
    step(1, DIVU_F);
    for (int j = 1; j < 10; j++) step(0, '0);
    start = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs_vec !== 28'h0 || ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_div obs=%h/%b exp=0/1", obs_vec, ready);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL reset_no_done obs=%b exp=0", done);
    end
    reset = 1'b1;
    test_divu("div_after_rst", 0, '0);
  endtask

`ifdef HILO_INTERLOCK_EN
  task automatic test_hilo();
    step(1, DIVU_F);
    for (int j = 1; j <= N; j++) begin
      step(j == 5 || j == 8, (j == 5) ? MFHI_F : ((j == 8) ? MFLO_F : 6'h0));
      n_vec++;
      if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL hilo_cyc%0d obs=%h/%b exp=%h/%b", j + 1, obs_vec, obs_ready,
                          exp_vec, exp_ready);
      end
    end
    n_vec++;
    if (SignaltoMUX !== MFHI_F || done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL hilo_exec obs mux=%b done=%b exp mux=%b done=1", SignaltoMUX, done,
                        MFHI_F);
    end
    step(0, '0);
  endtask
`endif

  task automatic test_random();
    logic [5:0] tbl [9];
    logic [5:0] f;
    int idx;
    tbl = '{AND_F, OR_F, ADD_F, SUB_F, SLT_F, SRL_F, DIVU_F, MFHI_F, MFLO_F};
    for (int i = 0; i < 3000; i++) begin
      idx = $urandom_range(0, 10);
      f = (idx < 9) ? tbl[idx] : 6'($urandom);
      if (idx == 6 && $urandom_range(0, 3) != 0) f = ADD_F;
      step($urandom_range(0, 2) != 0, f);
      n_vec++;
      if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL random_%0d f=%b obs=%h/%b exp=%h/%b", i, f, obs_vec, obs_ready,
                          exp_vec, exp_ready);
      end
    end
    step(0, '0);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_divu("divu", 0, '0);
    test_divu("div_rej", 10, ADD_F);
    test_illegal();
    test_reset_mid_div();
`ifdef HILO_INTERLOCK_EN
    test_hilo();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
